// File: rtl/parity_frame_rx.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : parity_frame_rx                                               |
// | Function : Serial parity-checking frame receiver. Assembles DATA_W bits  |
// |            LSB first plus one parity bit, flags mismatches and keeps a   |
// |            saturating error count. Define PARITY_ODD_EN for odd parity.  |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module parity_frame_rx #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              bit_in,
    input  logic              bit_valid,
    input  logic              clr,
    output logic [DATA_W-1:0] word_out,
    output logic              word_valid,
    output logic              parity_err,
    output logic              busy,
    output logic [CNT_W-1:0]  err_count
);

    localparam int c_idx_w = (DATA_W > 1) ? $clog2(DATA_W) : 1;

`ifdef PARITY_ODD_EN
    localparam logic c_odd = 1'b1;
`else
    localparam logic c_odd = 1'b0;
`endif

    typedef logic [c_idx_w-1:0] idx_t;
    typedef logic [CNT_W-1:0]   cnt_t;

    localparam idx_t c_last_idx = idx_t'(DATA_W - 1);
    localparam cnt_t c_cnt_max  = '1;

    typedef enum logic [0:0] {
        S_DATA = 1'b0,
        S_PAR  = 1'b1
    } state_t;

    state_t            r_state;
    idx_t              r_index;
    logic              r_par;
    logic [DATA_W-1:0] r_shift;
    logic [DATA_W-1:0] r_word;
    logic              r_valid;
    logic              r_perr;
    cnt_t              r_count;

    state_t            w_state_nxt;
    idx_t              w_index_nxt;
    logic              w_par_nxt;
    logic [DATA_W-1:0] w_shift_nxt;
    logic [DATA_W-1:0] w_word_nxt;
    logic              w_valid_nxt;
    logic              w_perr_nxt;
    cnt_t              w_count_nxt;
    logic              w_err;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_DATA;
            r_index <= '0;
            r_par   <= 1'b0;
            r_shift <= '0;
            r_word  <= '0;
            r_valid <= 1'b0;
            r_perr  <= 1'b0;
            r_count <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_index <= w_index_nxt;
            r_par   <= w_par_nxt;
            r_shift <= w_shift_nxt;
            r_word  <= w_word_nxt;
            r_valid <= w_valid_nxt;
            r_perr  <= w_perr_nxt;
            r_count <= w_count_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_index_nxt = r_index;
        w_par_nxt   = r_par;
        w_shift_nxt = r_shift;
        w_word_nxt  = r_word;
        w_valid_nxt = 1'b0;
        w_perr_nxt  = r_perr;
        w_count_nxt = r_count;
        w_err       = r_par ^ bit_in ^ c_odd;

        // clr dominates any bit presented in the same cycle
        if (clr) begin
            w_state_nxt = S_DATA;
            w_index_nxt = '0;
            w_par_nxt   = 1'b0;
            w_shift_nxt = '0;
        end else if (bit_valid) begin
            case (r_state)
                S_DATA: begin
                    w_shift_nxt[r_index] = bit_in;
                    w_par_nxt            = r_par ^ bit_in;
                    if (r_index == c_last_idx) begin
                        w_state_nxt = S_PAR;
                        w_index_nxt = '0;
                    end else begin
                        w_index_nxt = r_index + idx_t'(1);
                    end
                end
                S_PAR: begin
                    w_word_nxt  = r_shift;
                    w_perr_nxt  = w_err;
                    w_valid_nxt = 1'b1;
                    if (w_err && (r_count != c_cnt_max)) begin
                        w_count_nxt = r_count + cnt_t'(1);
                    end
                    w_state_nxt = S_DATA;
                    w_index_nxt = '0;
                    w_par_nxt   = 1'b0;
                end
                default: begin
                    w_state_nxt = S_DATA;
                    w_index_nxt = '0;
                    w_par_nxt   = 1'b0;
                end
            endcase
        end
    end

    assign word_out   = r_word;
    assign word_valid = r_valid;
    assign parity_err = r_perr;
    assign err_count  = r_count;
    assign busy       = (r_state == S_PAR) || (r_index != '0);

endmodule
`default_nettype wire

// File: tb/tb_parity_frame_rx.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_parity_frame_rx                                            |
// | Function : Scoreboard bench for parity_frame_rx (DATA_W=8, CNT_W=8).     |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module tb_parity_frame_rx;

`ifdef PARITY_ODD_EN
    localparam logic c_odd = 1'b1;
`else
    localparam logic c_odd = 1'b0;
`endif

    logic       clk;
    logic       rst;
    logic       bit_in;
    logic       bit_valid;
    logic       clr;
    logic [7:0] word_out;
    logic       word_valid;
    logic       parity_err;
    logic       busy;
    logic [7:0] err_count;

    typedef struct packed {
        logic [7:0] word;
        logic       perr;
        logic [7:0] cnt;
    } exp_t;

    exp_t sb[$];
    int   n_vec  = 0;
    int   n_fail = 0;
    int   exp_cnt = 0;

    parity_frame_rx #(
        .DATA_W(8),
        .CNT_W (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .bit_in    (bit_in),
        .bit_valid (bit_valid),
        .clr       (clr),
        .word_out  (word_out),
        .word_valid(word_valid),
        .parity_err(parity_err),
        .busy      (busy),
        .err_count (err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every word_valid pulse must match the oldest expectation
    always @(negedge clk) begin
        if (!rst && word_valid === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_word_valid", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("word_out",   {24'd0, word_out},  {24'd0, e.word});
                check("parity_err", {31'd0, parity_err}, {31'd0, e.perr});
                check("err_count",  {24'd0, err_count}, {24'd0, e.cnt});
            end
        end
    end

    task automatic drive_bit(input logic b, input bit gap);
        bit_valid = 1'b1;
        bit_in    = b;
        @(posedge clk);
        #1;
        bit_valid = 1'b0;
        bit_in    = 1'b0;
        if (gap) begin
            @(posedge clk);
            #1;
        end
    endtask

    // perr_even is the hand-computed result for the even-parity build
    task automatic send_frame(input logic [7:0] data, input logic par,
                              input logic perr_even, input bit gap);
        exp_t e;
        logic perr;
        for (int i = 0; i < 8; i++) drive_bit(data[i], gap);
        perr = perr_even ^ c_odd;
        if (perr && exp_cnt < 255) exp_cnt++;
        e.word = data;
        e.perr = perr;
        e.cnt  = 8'(exp_cnt);
        sb.push_back(e);
        drive_bit(par, 1'b0);
        check("latency_word_valid", {31'd0, word_valid}, 32'd1);
    endtask

    initial begin
        #1000000;
        $display("FAIL timeout: got running, expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        rst       = 1'b1;
        bit_in    = 1'b0;
        bit_valid = 1'b0;
        clr       = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_word_out",   {24'd0, word_out},  32'd0);
        check("rst_word_valid", {31'd0, word_valid}, 32'd0);
        check("rst_parity_err", {31'd0, parity_err}, 32'd0);
        check("rst_busy",       {31'd0, busy},       32'd0);
        check("rst_err_count",  {24'd0, err_count},  32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;

        // clean frame, then error/clean pair back-to-back
        send_frame(8'hA5, 1'b0, 1'b0, 1'b0);
        send_frame(8'h01, 1'b0, 1'b1, 1'b0);
        send_frame(8'h01, 1'b1, 1'b0, 1'b0);

        // gaps on every other cycle
        send_frame(8'h3C, 1'b0, 1'b0, 1'b1);
        @(posedge clk);
        #1;
        check("hold_word_out", {24'd0, word_out}, 32'h3C);

        // abort after 4 bits with clr alongside a valid bit
        for (int i = 0; i < 4; i++) drive_bit(1'b1, 1'b0);
        check("busy_mid_frame", {31'd0, busy}, 32'd1);
        clr       = 1'b1;
        bit_valid = 1'b1;
        bit_in    = 1'b1;
        @(posedge clk);
        #1;
        clr       = 1'b0;
        bit_valid = 1'b0;
        bit_in    = 1'b0;
        check("clr_busy",       {31'd0, busy},       32'd0);
        check("clr_word_valid", {31'd0, word_valid}, 32'd0);
        check("clr_word_out",   {24'd0, word_out},   32'h3C);
        send_frame(8'h3C, 1'b0, 1'b0, 1'b0);

        // abort on the parity bit itself: no pulse, no count
        for (int i = 0; i < 8; i++) drive_bit(1'b1, 1'b0);
        clr       = 1'b1;
        bit_valid = 1'b1;
        bit_in    = ~c_odd;
        @(posedge clk);
        #1;
        clr       = 1'b0;
        bit_valid = 1'b0;
        check("clr_par_word_valid", {31'd0, word_valid}, 32'd0);
        check("clr_par_err_count",  {24'd0, err_count},  32'(exp_cnt));

        // saturation: 257 parity-error frames
        for (int k = 0; k < 257; k++) send_frame(8'h01, c_odd, 1'b1 ^ c_odd, 1'b0);
        @(negedge clk);
        check("sat_err_count", {24'd0, err_count}, 32'hFF);

        // asynchronous reset mid-frame
        @(posedge clk);
        #1;
        for (int i = 0; i < 5; i++) drive_bit(1'b1, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_err_count",  {24'd0, err_count},  32'd0);
        check("async_rst_word_out",   {24'd0, word_out},   32'd0);
        check("async_rst_busy",       {31'd0, busy},       32'd0);
        check("async_rst_word_valid", {31'd0, word_valid}, 32'd0);
        exp_cnt = 0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        check("post_rst_busy", {31'd0, busy}, 32'd0);

        // fresh frame after reset
        send_frame(8'hA5, 1'b1, 1'b1, 1'b0);
        repeat (3) @(posedge clk);
        check("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
